// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - shared defaults for the scoreboarded register file
package regfile_pkg;
    localparam int DEF_DATA_W   = 32;
    localparam int DEF_ADDR_W   = 5;
    localparam int DEF_NUM_READ = 2;
    localparam int DEF_ZERO_REG = 1;
    localparam int DEF_BYPASS   = 1;
endpackage

// File: rtl/register_scoreboard.sv
// rtl/register_scoreboard.sv - pending-reservation bit vector with registered population count
module register_scoreboard
    import regfile_pkg::*;
#(
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int ZERO_REG = DEF_ZERO_REG
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  wr_en_i,
    input  logic [ADDR_W-1:0]     wr_addr_i,
    input  logic                  iss_en_i,
    input  logic [ADDR_W-1:0]     iss_addr_i,
    output logic [(1<<ADDR_W)-1:0] pending_o,
    output logic [ADDR_W:0]       count_o
);
    localparam int DEPTH = 1 << ADDR_W;
    localparam int CNT_W = ADDR_W + 1;

    logic [DEPTH-1:0] pending_q, pending_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             set_ok, clr_ok, inc, dec;

    always_comb begin
        set_ok    = iss_en_i && ((ZERO_REG == 0) || (iss_addr_i != '0));
        clr_ok    = wr_en_i  && ((ZERO_REG == 0) || (wr_addr_i  != '0));
        pending_d = pending_q;
        if (clr_ok) pending_d[wr_addr_i]  = 1'b0;
        // issue is applied last so a same-cycle new producer keeps the reservation
        if (set_ok) pending_d[iss_addr_i] = 1'b1;
        inc     = set_ok && !pending_q[iss_addr_i];
        dec     = clr_ok && pending_q[wr_addr_i] && !(set_ok && (iss_addr_i == wr_addr_i));
        count_d = count_q + CNT_W'(inc) - CNT_W'(dec);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            pending_q <= '0;
            count_q   <= '0;
        end else begin
            pending_q <= pending_d;
            count_q   <= count_d;
        end
    end

    assign pending_o = pending_q;
    assign count_o   = count_q;
endmodule

// File: rtl/scoreboard_register_file.sv
// rtl/scoreboard_register_file.sv - flop-array register file with async reads, write bypass and issue scoreboard
module scoreboard_register_file
    import regfile_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int NUM_READ = DEF_NUM_READ,
    parameter int ZERO_REG = DEF_ZERO_REG,
    parameter int BYPASS   = DEF_BYPASS
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic [NUM_READ*ADDR_W-1:0] RA,
    output logic [NUM_READ*DATA_W-1:0] BusA,
    output logic [NUM_READ-1:0]        busy,
    input  logic [ADDR_W-1:0]          RW,
    input  logic [DATA_W-1:0]          BusW,
    input  logic                       sig_enable_write,
    input  logic [ADDR_W-1:0]          RI,
    input  logic                       sig_issue,
    output logic [ADDR_W:0]            pending_count
);
    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] regs_q [DEPTH];
    logic [DEPTH-1:0]  pending;
    logic              wr_ok;

    assign wr_ok = sig_enable_write && ((ZERO_REG == 0) || (RW != '0));

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int k = 0; k < DEPTH; k++) regs_q[k] <= '0;
        end else if (wr_ok) begin
            regs_q[RW] <= BusW;
        end
    end

    register_scoreboard #(
        .ADDR_W   (ADDR_W),
        .ZERO_REG (ZERO_REG)
    ) u_scoreboard (
        .clock      (clock),
        .reset      (reset),
        .wr_en_i    (sig_enable_write),
        .wr_addr_i  (RW),
        .iss_en_i   (sig_issue),
        .iss_addr_i (RI),
        .pending_o  (pending),
        .count_o    (pending_count)
    );

    always_comb begin
        logic [ADDR_W-1:0] ra;
        logic              fwd;
        BusA = '0;
        busy = '0;
        for (int i = 0; i < NUM_READ; i++) begin
            ra  = RA[i*ADDR_W +: ADDR_W];
            fwd = (BYPASS != 0) && wr_ok && (RW == ra);
            BusA[i*DATA_W +: DATA_W] = fwd ? BusW : regs_q[ra];
            busy[i]                  = pending[ra] && !fwd;
            if ((ZERO_REG != 0) && (ra == '0)) begin
                BusA[i*DATA_W +: DATA_W] = '0;
                busy[i]                  = 1'b0;
            end
        end
    end
endmodule
